// File: rtl/iob_timer_pkg.sv
// Shared constants for the iob_timer block.
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - Mode select constants for cfg_mode_i
package iob_timer_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'b01;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'b10;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'b11;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : iob_timer_pkg

// File: rtl/iob_timer_prescaler.sv
// Prescaler for iob_timer_ctrl: counts 0..presc_i while enabled and flags
// a step on the cycle the count reaches presc_i, then wraps to 0.
// Ports:
//   clk_i     - clock, rising edge
//   rst_n_i   - synchronous active-low reset
//   cke_i     - clock enable; counter holds while 0
//   clear_i   - return the counter to 0 (has priority over enable_i)
//   enable_i  - advance the counter this cycle
//   presc_i   - divide value minus 1
//   step_o    - combinational step strobe for the current cycle
module iob_timer_prescaler
  import iob_timer_pkg::*;
#(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cke_i,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               step_o
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_at_limit;

  // >= rather than == so that lowering presc_i while paused mid-count
  // still produces a step instead of running the counter all the way round.
  assign w_at_limit = (r_cnt >= presc_i);
  assign step_o     = enable_i && w_at_limit;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: non-blocking (<=) for every flop so all registers sample
      // pre-edge values; blocking here would create ordering races.
      r_cnt <= '0;
    end else if (cke_i) begin
      if (clear_i) begin
        r_cnt <= '0;
      end else if (enable_i) begin
        r_cnt <= w_at_limit ? '0 : r_cnt + PRESC_W'(1);
      end
    end
  end

endmodule : iob_timer_prescaler

// File: rtl/iob_timer_ctrl.sv
// Programmable timer controller with IDLE/RUN/PAUSE/DONE FSM,
// prescaled counting, one-shot or periodic expiry and a registered tick.
// Ports:
//   clk_i, rst_n_i        - clock and synchronous active-low reset
//   cke_i                 - clock enable; everything holds while 0
//   cfg_valid_i/ready_o   - configuration handshake (ready outside RUN)
//   cfg_period_i          - terminal count
//   cfg_presc_i           - prescaler divide value minus 1
//   cfg_mode_i            - 0 one-shot, 1 periodic
//   start_i, stop_i       - single-cycle commands (stop wins on collision)
//   busy_o, done_o        - high in RUN / DONE
//   tick_o                - one-cycle expiry pulse
//   count_o, state_o      - current count and FSM state code
module iob_timer_ctrl
  import iob_timer_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cke_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [DATA_W-1:0]  cfg_period_i,
  input  logic [PRESC_W-1:0] cfg_presc_i,
  input  logic               cfg_mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               busy_o,
  output logic               tick_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  count_o,
  output logic [1:0]         state_o
);

  logic [STATE_W-1:0] r_state;
  logic [DATA_W-1:0]  r_count;
  logic [DATA_W-1:0]  r_period;
  logic [PRESC_W-1:0] r_presc;
  logic               r_mode;
  logic               r_tick;

  logic w_cfg_fire;
  logic w_start_new;
  logic w_abort;
  logic w_presc_clear;
  logic w_presc_en;
  logic w_step;
  logic w_expiry;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_cfg_fire    = 1'b0;
    w_start_new   = 1'b0;
    w_abort       = 1'b0;
    w_presc_en    = 1'b0;
    w_presc_clear = 1'b0;

    w_cfg_fire  = cfg_valid_i && (r_state != ST_RUN);
    // A fresh start (from IDLE/DONE) only when stop_i is not also present.
    w_start_new = start_i && !stop_i &&
                  ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_abort     = stop_i && (r_state == ST_PAUSE);
    // A stop in RUN freezes the prescaler on the same edge it pauses.
    w_presc_en  = (r_state == ST_RUN) && !stop_i;
    // Leaving DONE via configuration also resets the prescaler for the next run.
    w_presc_clear = w_start_new || w_abort ||
                    (w_cfg_fire && (r_state == ST_DONE));
  end

  assign w_expiry = w_step && (r_count >= r_period);

  iob_timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .cke_i    (cke_i),
    .clear_i  (w_presc_clear),
    .enable_i (w_presc_en),
    .presc_i  (r_presc),
    .step_o   (w_step)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: only control/config flops exist here, all of them reset;
      // there is no storage array that would be left unreset.
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_presc  <= '0;
      r_mode   <= MODE_ONESHOT;
      r_tick   <= 1'b0;
    end else if (cke_i) begin
      r_tick <= w_expiry;

      if (w_cfg_fire) begin
        r_period <= cfg_period_i;
        r_presc  <= cfg_presc_i;
        r_mode   <= cfg_mode_i;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_new) begin
            r_state <= ST_RUN;
            r_count <= '0;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            r_state <= ST_PAUSE;
          end else if (w_expiry) begin
            if (r_mode == MODE_PERIODIC) begin
              r_count <= '0;
            end else begin
              r_state <= ST_DONE;
            end
          end else if (w_step) begin
            r_count <= r_count + DATA_W'(1);
          end
        end
        ST_PAUSE: begin
          if (stop_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else if (start_i) begin
            r_state <= ST_RUN;
          end
        end
        default: begin  // ST_DONE
          if (w_start_new) begin
            r_state <= ST_RUN;
            r_count <= '0;
          end else if (w_cfg_fire) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
        end
      endcase
    end
  end

  // The tick is gated so it never shows while the block is frozen; a tick
  // pending across a frozen stretch appears on the first enabled cycle.
  assign tick_o      = r_tick && cke_i;
  assign cfg_ready_o = (r_state != ST_RUN);
  assign busy_o      = (r_state == ST_RUN);
  assign done_o      = (r_state == ST_DONE);
  assign count_o     = r_count;
  assign state_o     = r_state;

endmodule : iob_timer_ctrl

// File: tb/tb_iob_timer_ctrl.sv
// Directed self-checking bench for iob_timer_ctrl.
module tb_iob_timer_ctrl;

  localparam int DATA_W  = 32;
  localparam int PRESC_W = 16;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cke;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DATA_W-1:0]  cfg_period;
  logic [PRESC_W-1:0] cfg_presc;
  logic               cfg_mode;
  logic               start;
  logic               stop;
  logic               busy;
  logic               tick;
  logic               done;
  logic [DATA_W-1:0]  count;
  logic [1:0]         state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iob_timer_ctrl #(
    .DATA_W  (DATA_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cke_i        (cke),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_period_i (cfg_period),
    .cfg_presc_i  (cfg_presc),
    .cfg_mode_i   (cfg_mode),
    .start_i      (start),
    .stop_i       (stop),
    .busy_o       (busy),
    .tick_o       (tick),
    .done_o       (done),
    .count_o      (count),
    .state_o      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling/driving.
  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_core(input string tag, input logic [1:0] st,
                            input logic [31:0] cnt, input logic tk);
    check({tag, ".state"}, {30'd0, state}, {30'd0, st});
    check({tag, ".count"}, count, cnt);
    check({tag, ".tick"}, {31'd0, tick}, {31'd0, tk});
  endtask

  task automatic do_cfg(input logic [31:0] per, input logic [15:0] psc, input logic md);
    cfg_valid  = 1'b1;
    cfg_period = per;
    cfg_presc  = psc;
    cfg_mode   = md;
    step_cyc();
    cfg_valid  = 1'b0;
  endtask

  task automatic pulse(input logic st, input logic sp);
    start = st;
    stop  = sp;
    step_cyc();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cke = 1'b1; cfg_valid = 1'b0; cfg_period = '0;
    cfg_presc = '0; cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
    #1;
    step_cyc();
    step_cyc();

    // Reset state
    check_core("rst", S_IDLE, 0, 1'b0);
    check("rst.busy",  {31'd0, busy},      0);
    check("rst.done",  {31'd0, done},      0);
    check("rst.ready", {31'd0, cfg_ready}, 1);
    rst_n = 1'b1;

    // Periodic, period=3, presc=0: 0,1,2,3 then tick with count back at 0
    do_cfg(3, 0, 1'b1);
    check("a.cfg_idle", {30'd0, state}, {30'd0, S_IDLE});
    pulse(1'b1, 1'b0);
    check_core("a.e0", S_RUN, 0, 1'b0);
    check("a.busy",  {31'd0, busy},      1);
    check("a.ready", {31'd0, cfg_ready}, 0);
    for (int k = 1; k <= 8; k++) begin
      step_cyc();
      check_core($sformatf("a.e%0d", k), S_RUN, k % 4, (k % 4) == 0);
    end
    pulse(1'b0, 1'b1);
    check_core("a.pause", S_PAUSE, 0, 1'b0);
    pulse(1'b0, 1'b1);
    check_core("a.abort", S_IDLE, 0, 1'b0);

    // One-shot, period=2, presc=1: tick on edge 6 after start, DONE with count 2
    do_cfg(2, 1, 1'b0);
    pulse(1'b1, 1'b0);
    check_core("b.e0", S_RUN, 0, 1'b0);
    step_cyc(); check_core("b.e1", S_RUN, 0, 1'b0);
    step_cyc(); check_core("b.e2", S_RUN, 1, 1'b0);
    step_cyc(); check_core("b.e3", S_RUN, 1, 1'b0);
    step_cyc(); check_core("b.e4", S_RUN, 2, 1'b0);
    step_cyc(); check_core("b.e5", S_RUN, 2, 1'b0);
    step_cyc(); check_core("b.e6", S_DONE, 2, 1'b1);
    check("b.done",  {31'd0, done},      1);
    check("b.ready", {31'd0, cfg_ready}, 1);
    check("b.busy",  {31'd0, busy},      0);
    step_cyc(); check_core("b.hold", S_DONE, 2, 1'b0);
    // Configuration in DONE returns to IDLE and clears count
    do_cfg(9, 0, 1'b1);
    check_core("b.cfg_done", S_IDLE, 0, 1'b0);

    // Pause at count 5 (period 9), lower period to 3, resume: expiry on next step
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) step_cyc();
    check_core("c.run5", S_RUN, 5, 1'b0);
    pulse(1'b0, 1'b1);
    check_core("c.pause", S_PAUSE, 5, 1'b0);
    step_cyc();
    check_core("c.hold", S_PAUSE, 5, 1'b0);
    do_cfg(3, 0, 1'b1);
    check_core("c.recfg", S_PAUSE, 5, 1'b0);
    pulse(1'b1, 1'b0);
    check_core("c.resume", S_RUN, 5, 1'b0);
    step_cyc();
    check_core("c.expire", S_RUN, 0, 1'b1);

    // start+stop together in RUN: stop wins -> PAUSE; second stop -> IDLE
    step_cyc();
    check_core("d.run1", S_RUN, 1, 1'b0);
    pulse(1'b1, 1'b1);
    check_core("d.both", S_PAUSE, 1, 1'b0);
    pulse(1'b0, 1'b1);
    check_core("d.abort", S_IDLE, 0, 1'b0);
    pulse(1'b0, 1'b1);
    check_core("d.ignored", S_IDLE, 0, 1'b0);

    // Clock-enable hold, then reset with cke=0 mid-RUN
    pulse(1'b1, 1'b0);
    step_cyc();
    step_cyc();
    check_core("e.run2", S_RUN, 2, 1'b0);
    cke = 1'b0;
    start = 1'b1; stop = 1'b1;
    step_cyc();
    step_cyc();
    start = 1'b0; stop = 1'b0;
    check_core("e.cke_hold", S_RUN, 2, 1'b0);
    rst_n = 1'b0;
    step_cyc();
    check_core("e.rst", S_IDLE, 0, 1'b0);
    check("e.busy",  {31'd0, busy},      0);
    check("e.done",  {31'd0, done},      0);
    check("e.ready", {31'd0, cfg_ready}, 1);
    rst_n = 1'b1;
    cke   = 1'b1;
    step_cyc();
    check_core("e.after", S_IDLE, 0, 1'b0);

    // period=0, presc=0, periodic: tick every cycle, cfg refused in RUN
    do_cfg(0, 0, 1'b1);
    pulse(1'b1, 1'b0);
    check_core("f.e0", S_RUN, 0, 1'b0);
    cfg_valid = 1'b1; cfg_period = 7; cfg_mode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step_cyc();
      check_core($sformatf("f.e%0d", k), S_RUN, 0, 1'b1);
      check($sformatf("f.ready%0d", k), {31'd0, cfg_ready}, 0);
    end
    cfg_valid = 1'b0;
    pulse(1'b0, 1'b1);
    check_core("f.pause", S_PAUSE, 0, 1'b0);
    pulse(1'b1, 1'b0);
    check_core("f.resume", S_RUN, 0, 1'b0);
    step_cyc();
    check_core("f.keep_cfg", S_RUN, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_iob_timer_ctrl

// File: doc/iob_timer_ctrl.md
IOB_TIMER_CTRL -- requirements
Module: iob_timer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the period and count values.
REQ-002 SHALL have parameter PRESC_W, default 16, the width of the prescaler value.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port cke_i, input, 1 bit: clock enable; while 0, all registers hold.
REQ-006 SHALL have port cfg_valid_i, input, 1 bit: a configuration request is present.
REQ-007 SHALL have port cfg_ready_o, output, 1 bit: configuration can be accepted.
REQ-008 SHALL have port cfg_period_i, input, DATA_W bits: terminal count.
REQ-009 SHALL have port cfg_presc_i, input, PRESC_W bits: prescaler divide value minus 1.
REQ-010 SHALL have port cfg_mode_i, input, 1 bit: 0 selects one-shot, 1 selects periodic.
REQ-011 SHALL have ports start_i and stop_i, inputs, 1 bit each: single-cycle command pulses.
REQ-012 SHALL have port busy_o, output, 1 bit: high in RUN.
REQ-013 SHALL have port tick_o, output, 1 bit: one-cycle expiry pulse.
REQ-014 SHALL have port done_o, output, 1 bit: high in DONE.
REQ-015 SHALL have port count_o, output, DATA_W bits: current count.
REQ-016 SHALL have port state_o, output, 2 bits: FSM state code.

Function
REQ-017 FSM states SHALL be IDLE=00, RUN=01, PAUSE=10 and DONE=11.
REQ-018 cfg_ready_o SHALL be 1 in IDLE, PAUSE and DONE and 0 in RUN; a configuration transfers only when cfg_valid_i and cfg_ready_o are both 1 with cke_i=1.
REQ-019 A configuration transfer SHALL latch period, prescaler value and mode; in DONE it SHALL also move the FSM to IDLE and clear count_o.
REQ-020 start_i in IDLE or DONE SHALL enter RUN with count_o=0 and the prescaler cleared.
REQ-021 start_i in PAUSE SHALL enter RUN without altering count_o or the prescaler.
REQ-022 stop_i in RUN SHALL enter PAUSE with count_o and the prescaler held.
REQ-023 stop_i in PAUSE SHALL enter IDLE and clear count_o (abort).
REQ-024 When start_i and stop_i are asserted in the same cycle, stop_i SHALL win.
REQ-025 Commands that are not valid for the current state SHALL be ignored.
REQ-026 In RUN, the prescaler SHALL count 0..presc and generate a step on the cycle it equals presc, then wrap to 0; presc=0 SHALL give a step every cycle.
REQ-027 On a step, if count_o >= period this SHALL be an expiry; otherwise count_o SHALL increment by 1 with DATA_W wrap-around.
REQ-028 On an expiry, tick_o SHALL pulse high for exactly the next cycle (1-cycle registered latency).
REQ-029 On an expiry in periodic mode, count_o SHALL return to 0 and the FSM SHALL stay in RUN.
REQ-030 On an expiry in one-shot mode, count_o SHALL hold its value and the FSM SHALL enter DONE.
REQ-031 period=0 SHALL expire on every step with count_o remaining 0.
REQ-032 Reconfiguring in PAUSE with a new period below count_o SHALL cause an expiry on the first step after resume.
REQ-033 With cke_i=0: state, count and prescaler SHALL hold; commands and cfg_valid_i SHALL be ignored; tick_o SHALL be 0.

Reset
REQ-034 When rst_n_i=0 at a rising edge, the FSM SHALL enter IDLE regardless of cke_i.
REQ-035 On reset: count_o=0, prescaler=0, period=0, presc=0, mode=0, tick_o=0, busy_o=0, done_o=0, cfg_ready_o=1.
REQ-036 Reset asserted in RUN SHALL abort the run with no tick_o pulse produced.

Structure
REQ-037 State encodings and mode constants SHALL live in the shared package iob_timer_pkg.
REQ-038 The prescaler SHALL be a sub-module, iob_timer_prescaler (ports: clear, enable, presc value, step output).

Verification
REQ-039 Configure period=3, presc=0, periodic, then start: count 0,1,2,3 then tick_o at cycle 5, repeating every 4 cycles.
REQ-040 Configure period=2, presc=1, one-shot, then start: tick_o at cycle 7, DONE with count_o=2, cfg_ready_o=1.
REQ-041 Running at count=5 with period=9: stop_i gives PAUSE; reconfigure period=3; start_i gives tick_o on the next step.
REQ-042 start_i and stop_i asserted together in RUN: PAUSE; a second stop_i: IDLE with count_o=0.
REQ-043 rst_n_i=0 for 1 cycle mid-RUN with cke_i=0: IDLE, all outputs at reset values, no tick_o.
REQ-044 period=0, presc=0, periodic: tick_o high every cycle from cycle 2 with count_o=0; cfg_valid_i is not accepted while in RUN.
